// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit word feeder.
// Feeder FSM states plus default byte/word/FIFO sizes.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int unsigned NB_DATA_DEF    = 8;
    localparam int unsigned NB_WORD_DEF    = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Byte counter width: enough to index every byte of a word, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_word_feeder_if.sv
// Host-side word push and topTx byte handshake bundle for the UART word feeder.
// The optional FIFO level signal exists only when UART_TX_LEVEL_EN is defined.
interface uart_tx_word_feeder_if #(
    parameter int unsigned NB_DATA    = uart_tx_pkg::NB_DATA_DEF,
    parameter int unsigned NB_WORD    = uart_tx_pkg::NB_WORD_DEF,
    parameter int unsigned FIFO_DEPTH = uart_tx_pkg::FIFO_DEPTH_DEF
);
    localparam int unsigned NB_ADDR = $clog2(FIFO_DEPTH);

    logic               wr_en;
    logic [NB_WORD-1:0] wr_word;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               tx_done_tick;
    logic               tx_start;
    logic [NB_DATA-1:0] din;
    logic               busy;

`ifdef UART_TX_LEVEL_EN
    logic [NB_ADDR:0]   level;

    modport master (
        output wr_en, wr_word, tx_done_tick,
        input  full, empty, overflow, tx_start, din, busy, level
    );
    modport slave (
        input  wr_en, wr_word, tx_done_tick,
        output full, empty, overflow, tx_start, din, busy, level
    );
`else
    modport master (
        output wr_en, wr_word, tx_done_tick,
        input  full, empty, overflow, tx_start, din, busy
    );
    modport slave (
        input  wr_en, wr_word, tx_done_tick,
        output full, empty, overflow, tx_start, din, busy
    );
`endif

endinterface

// File: rtl/tx_word_fifo.sv
// Synchronous word FIFO with registered full/empty derived from the occupancy count.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module tx_word_fifo #(
    parameter int unsigned NB_WORD    = uart_tx_pkg::NB_WORD_DEF,
    parameter int unsigned FIFO_DEPTH = uart_tx_pkg::FIFO_DEPTH_DEF,
    localparam int unsigned NB_ADDR   = $clog2(FIFO_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [NB_WORD-1:0] wr_data,
    input  logic               rd_en,
    output logic [NB_WORD-1:0] rd_data,
    output logic               full,
    output logic               empty,
    output logic [NB_ADDR:0]   count
);
    localparam logic [NB_ADDR:0] DEPTH_CNT = (NB_ADDR+1)'(FIFO_DEPTH);

    logic [NB_WORD-1:0] mem_q [FIFO_DEPTH];
    logic [NB_ADDR-1:0] wr_ptr_q;
    logic [NB_ADDR-1:0] rd_ptr_q;
    logic [NB_ADDR:0]   count_q;
    logic [NB_ADDR:0]   count_d;
    logic               full_q;
    logic               empty_q;
    logic               wr_ok;
    logic               rd_ok;

    assign rd_ok = rd_en && !empty_q;
    assign wr_ok = wr_en && (!full_q || rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (NB_ADDR+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - (NB_ADDR+1)'(1);
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + NB_ADDR'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + NB_ADDR'(1);
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Buffers words and feeds them to topTx one byte at a time, LSB byte first.
// Define UART_TX_LEVEL_EN to expose the live FIFO occupancy on the level signal.
module uart_tx_word_feeder
    import uart_tx_pkg::*;
#(
    parameter int unsigned NB_DATA    = NB_DATA_DEF,
    parameter int unsigned NB_WORD    = NB_WORD_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_word_feeder_if.slave  bus
);
    localparam int unsigned NB_ADDR   = $clog2(FIFO_DEPTH);
    localparam int unsigned NB_BYTES  = NB_WORD / NB_DATA;
    localparam int unsigned NB_CNT    = cnt_width(NB_BYTES);
    localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_ADDR:0]   DEPTH_CNT = (NB_ADDR+1)'(FIFO_DEPTH);

    state_e             state_q;
    logic [NB_WORD-1:0] shreg_q;
    logic [NB_WORD-1:0] shreg_sh;
    logic [NB_CNT-1:0]  byte_cnt_q;
    logic [NB_DATA-1:0] din_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               overflow_q;
    logic               rd_en;
    logic [NB_WORD-1:0] rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NB_ADDR:0]   fifo_count;

    assign rd_en    = (state_q == IDLE) && !fifo_empty;
    assign shreg_sh = shreg_q >> NB_DATA;

    tx_word_fifo #(
        .NB_WORD    (NB_WORD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // din/tx_start are loaded on the edge entering START so the pulse coincides with START.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            din_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (bus.wr_en && (fifo_count == DEPTH_CNT) && !rd_en) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg_q    <= rd_data;
                        byte_cnt_q <= '0;
                        din_q      <= rd_data[NB_DATA-1:0];
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q    <= shreg_sh;
                            byte_cnt_q <= byte_cnt_q + NB_CNT'(1);
                            din_q      <= shreg_sh[NB_DATA-1:0];
                            tx_start_q <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow_q;
    assign bus.tx_start = tx_start_q;
    assign bus.din      = din_q;
    assign bus.busy     = busy_q;
`ifdef UART_TX_LEVEL_EN
    assign bus.level    = fifo_count;
`endif

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Directed bench for uart_tx_word_feeder; tx_done_tick is driven directly in place of topTx.
// Checks reset, byte order, inter-byte gaps, full/overflow behaviour and spurious done ticks.
module tb_uart_tx_word_feeder;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_word_feeder_if #(.NB_DATA(8), .NB_WORD(32), .FIFO_DEPTH(8)) bus ();

    uart_tx_word_feeder #(
        .NB_DATA    (8),
        .NB_WORD    (32),
        .FIFO_DEPTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word k carries bytes 16k+0 .. 16k+3, LSB byte first.
    function automatic logic [31:0] wk(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(16*k + j);
        return w;
    endfunction

    // Pulse tx_done_tick in WAIT, then expect the next tx_start after exp_gap cycles.
    task automatic done_and_expect(input string tag, input logic [7:0] exp_din, input int exp_gap);
        int gap;
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        gap = 1;
        while (!bus.tx_start && gap < 8) begin
            step();
            gap++;
        end
        check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        check({tag, "_din"}, 32'(bus.din), 32'(exp_din));
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_word = '0;
        bus.tx_done_tick = 1'b0;

        // Reset state
        step();
        step();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_txs", 32'(bus.tx_start), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef UART_TX_LEVEL_EN
        check("rst_level", 32'(bus.level), 32'd0);
`endif
        reset = 1'b1;
        step();

        // Async reset while a word is in flight with another queued
        bus.wr_en = 1'b1;
        bus.wr_word = 32'h11223344;
        step();
        bus.wr_word = 32'h55667788;
        step();
        bus.wr_en = 1'b0;
        check("t1_txs", 32'(bus.tx_start), 32'd1);
        check("t1_din", 32'(bus.din), 32'h44);
        check("t1_empty", 32'(bus.empty), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t1_rst_txs", 32'(bus.tx_start), 32'd0);
        check("t1_rst_din", 32'(bus.din), 32'd0);
        check("t1_rst_busy", 32'(bus.busy), 32'd0);
        check("t1_rst_empty", 32'(bus.empty), 32'd1);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t1_idle_txs%0d", i), 32'(bus.tx_start), 32'd0);
            check($sformatf("t1_idle_busy%0d", i), 32'(bus.busy), 32'd0);
        end

        // Single word DEADBEEF
        bus.wr_en = 1'b1;
        bus.wr_word = 32'hDEADBEEF;
        step();
        bus.wr_en = 1'b0;
        check("t2_empty", 32'(bus.empty), 32'd0);
        check("t2_txs0", 32'(bus.tx_start), 32'd0);
        step();
        check("t2_txs1", 32'(bus.tx_start), 32'd1);
        check("t2_din0", 32'(bus.din), 32'hEF);
        check("t2_busy", 32'(bus.busy), 32'd1);
        step();
        check("t2_txs_drop", 32'(bus.tx_start), 32'd0);
        check("t2_din_hold", 32'(bus.din), 32'hEF);
        done_and_expect("t2_b1", 8'hBE, 1);
        done_and_expect("t2_b2", 8'hAD, 1);
        done_and_expect("t2_b3", 8'hDE, 1);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        check("t2_busy_end", 32'(bus.busy), 32'd0);
        check("t2_txs_end", 32'(bus.tx_start), 32'd0);
        step();
        check("t2_empty_end", 32'(bus.empty), 32'd1);

        // Three words back-to-back
        bus.wr_en = 1'b1;
        bus.wr_word = 32'h03020100;
        step();
        bus.wr_word = 32'h07060504;
        step();
        check("t3_txs0", 32'(bus.tx_start), 32'd1);
        check("t3_din0", 32'(bus.din), 32'h00);
        bus.wr_word = 32'h0B0A0908;
        step();
        bus.wr_en = 1'b0;
        for (int b = 1; b < 12; b++) begin
            done_and_expect($sformatf("t3_b%0d", b), 8'(b), ((b % 4) == 0) ? 2 : 1);
        end
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        check("t3_busy_end", 32'(bus.busy), 32'd0);

        // Stall with a word in flight, then fill the FIFO
        bus.wr_en = 1'b1;
        bus.wr_word = 32'hF3F2F1F0;
        step();
        bus.wr_en = 1'b0;
        step();
        check("t4_din0", 32'(bus.din), 32'hF0);
        step();
        for (int k = 1; k <= 8; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_word = wk(k);
            step();
            check($sformatf("t4_full%0d", k), 32'(bus.full), (k == 8) ? 32'd1 : 32'd0);
        end
        bus.wr_en = 1'b0;
        check("t4_ovf0", 32'(bus.overflow), 32'd0);
`ifdef UART_TX_LEVEL_EN
        check("t4_level", 32'(bus.level), 32'd8);
`endif
        done_and_expect("t4_b1", 8'hF1, 1);
        done_and_expect("t4_b2", 8'hF2, 1);
        done_and_expect("t4_b3", 8'hF3, 1);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;

        // Push while full in the same cycle the FSM pops
        bus.wr_en = 1'b1;
        bus.wr_word = wk(9);
        step();
        check("t5_full", 32'(bus.full), 32'd1);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
        check("t5_txs", 32'(bus.tx_start), 32'd1);
        check("t5_din", 32'(bus.din), 32'h10);
`ifdef UART_TX_LEVEL_EN
        check("t5_level", 32'(bus.level), 32'd8);
`endif
        // Push while full with no pop: dropped, overflow sticks
        bus.wr_word = wk(14);
        step();
        bus.wr_en = 1'b0;
        check("t4_ovf_set", 32'(bus.overflow), 32'd1);
        check("t4_full_hold", 32'(bus.full), 32'd1);
        step();
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Drain: words 1..9 in order, dropped word 14 never appears
        for (int j = 1; j < 4; j++) begin
            done_and_expect($sformatf("t5_w1b%0d", j), 8'(16 + j), 1);
        end
        for (int k = 2; k <= 9; k++) begin
            for (int j = 0; j < 4; j++) begin
                done_and_expect($sformatf("t5_w%0db%0d", k, j), 8'(16*k + j), (j == 0) ? 2 : 1);
            end
        end
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        check("t5_busy_end", 32'(bus.busy), 32'd0);
        step();
        check("t5_empty_end", 32'(bus.empty), 32'd1);
        check("t5_ovf_end", 32'(bus.overflow), 32'd1);

        // Spurious tx_done_tick in IDLE
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        check("t6_txs", 32'(bus.tx_start), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_din", 32'(bus.din), 32'h93);
        step();
        check("t6_txs_later", 32'(bus.tx_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
